// File: rtl/cordic_vector_atan2.sv
// Iterative CORDIC vectoring engine: (x, y) -> atan2 phase (1.2.(PW-3) rad) and magnitude.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales the magnitude by 1/K.
module cordic_vector_atan2 #(
    parameter int IW   = 16,
    parameter int PW   = 16,
    parameter int ITER = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic signed [IW-1:0] s_x,
    input  logic signed [IW-1:0] s_y,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic signed [PW-1:0] m_phase,
    output logic        [IW+1:0] m_mag
);
    localparam int XW  = IW + 2;
    localparam int ZW  = PW + 1;
    localparam int CW  = $clog2(ITER + 1);
    localparam int SHL = (PW >= 16) ? PW - 16 : 0;
    localparam int SHR = (PW < 16) ? 16 - PW : 0;

    // Angle constants are tabulated at 13 fractional bits and rescaled for PW.
    function automatic int scale_q13(input int v);
        return (PW >= 16) ? (v <<< SHL) : ((v + ((1 <<< SHR) >>> 1)) >>> SHR);
    endfunction

    function automatic int atan_q13(input int k);
        int r;
        case (k)
            0: r = 6434;   1: r = 3798;   2: r = 2007;   3: r = 1019;
            4: r = 511;    5: r = 256;    6: r = 128;    7: r = 64;
            8: r = 32;     9: r = 16;    10: r = 8;     11: r = 4;
            12: r = 2;    13: r = 1;
            default: r = 0;
        endcase
        return r;
    endfunction

    localparam logic signed [ZW-1:0] PI_Z      = ZW'(scale_q13(25736));
    localparam logic signed [ZW-1:0] HALF_PI_Z = ZW'(scale_q13(12868));

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {IDLE, ROT, GAIN, DONE} state_t;
    localparam logic signed [XW+16:0] GAIN_K = (XW+17)'(19898);
    logic signed [XW+16:0] prod;
`else
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
`endif

    state_t state, state_nx;
    logic                 ready_en, zero, last;
    logic        [CW-1:0] i;
    logic signed [XW-1:0] x, y, x_nx, y_nx, x_sh, y_sh, sx, sy, pre_x, pre_y;
    logic signed [ZW-1:0] z, z_nx, pre_z, atan_z;
    logic signed [PW-1:0] phase_out;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ROT spends one extra pass (i == ITER) registering the result, giving ITER+1 latency.
    always_comb begin
        state_nx = state;
        s_tready = ready_en && (state == IDLE);
        m_tvalid = (state == DONE);
        last     = (i == CW'(ITER));
        case (state)
            IDLE: if (s_tvalid && s_tready) state_nx = ROT;
`ifdef CORDIC_GAIN_COMP_EN
            ROT:  if (last) state_nx = GAIN;
            GAIN: state_nx = DONE;
`else
            ROT:  if (last) state_nx = DONE;
`endif
            DONE: if (m_tready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sx    = XW'(s_x);
        sy    = XW'(s_y);
        pre_x = sx;
        pre_y = sy;
        pre_z = '0;
        if (s_x[IW-1]) begin
            if (!s_y[IW-1]) begin
                pre_x = sy;
                pre_y = -sx;
                pre_z = HALF_PI_Z;
            end else begin
                pre_x = -sy;
                pre_y = sx;
                pre_z = -HALF_PI_Z;
            end
        end

        x_sh   = x >>> i;
        y_sh   = y >>> i;
        atan_z = ZW'(scale_q13(atan_q13(int'(i))));
        if (!y[XW-1]) begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + atan_z;
        end else begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - atan_z;
        end

        if (zero)             phase_out = '0;
        else if (z > PI_Z)    phase_out = PW'(PI_Z);
        else if (z < -PI_Z)   phase_out = PW'(-PI_Z);
        else                  phase_out = PW'(z);
`ifdef CORDIC_GAIN_COMP_EN
        prod = (XW+17)'(x) * GAIN_K;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
            zero     <= 1'b0;
            i        <= '0;
            x        <= '0;
            y        <= '0;
            z        <= '0;
            m_phase  <= '0;
            m_mag    <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: if (s_tvalid && s_tready) begin
                    i    <= '0;
                    zero <= (s_x == '0) && (s_y == '0);
                    x    <= pre_x;
                    y    <= pre_y;
                    z    <= pre_z;
                end
                ROT: if (!last) begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    i <= i + 1'b1;
                end
`ifndef CORDIC_GAIN_COMP_EN
                else begin
                    m_phase <= phase_out;
                    m_mag   <= zero ? '0 : x;
                end
`else
                GAIN: begin
                    m_phase <= phase_out;
                    m_mag   <= zero ? '0 : XW'(prod >>> 15);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vector_atan2.sv
// Scoreboard bench for cordic_vector_atan2: directed vectors, backpressure, mid-operation reset.
module tb_cordic_vector_atan2;
    localparam int IW = 16, PW = 16, ITER = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 2;
    localparam bit GAIN_ON = 1'b1;
`else
    localparam int LAT = ITER + 1;
    localparam bit GAIN_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, s_tvalid, s_tready, m_tvalid, m_tready;
    logic signed [IW-1:0] s_x, s_y;
    logic signed [PW-1:0] m_phase;
    logic [IW+1:0] m_mag;

    always #5 clk = ~clk;

    cordic_vector_atan2 #(.IW(IW), .PW(PW), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_x(s_x), .s_y(s_y), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_phase(m_phase), .m_mag(m_mag)
    );

    typedef struct {
        int    ph;
        int    ph_tol;
        int    mag;
        int    mag_tol;
        bit    abs_ph;
        int    acc;
        string name;
    } exp_t;

    exp_t sb[$];
    int compared = 0, mismatched = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req, input int tol);
        compared++;
        if (act - req > tol || req - act > tol) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, req, tol);
        end
    endtask

    // Monitor: latency on the rising edge of m_tvalid, values on each handshake.
    logic prev_v = 1'b0;
    exp_t e;
    int ph;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_v <= 1'b0;
        end else begin
            if (m_tvalid === 1'b1 && !prev_v) begin
                if (sb.size() == 0) check("unexpected_valid", 1, 0, 0);
                else check({sb[0].name, "_latency"}, cyc - sb[0].acc, LAT, 0);
            end
            if (m_tvalid === 1'b1 && m_tready === 1'b1 && sb.size() > 0) begin
                e  = sb.pop_front();
                ph = int'(m_phase);
                check({e.name, "_range"}, int'(ph > 25736 || ph < -25736), 0, 0);
                if (e.abs_ph && ph < 0) ph = -ph;
                check({e.name, "_phase"}, ph, e.ph, e.ph_tol);
                check({e.name, "_mag"}, int'(m_mag), e.mag, e.mag_tol);
            end
            prev_v <= (m_tvalid === 1'b1);
        end
    end

    task automatic send(input int x, input int y, input int ph, input int pt, input int mag,
                        input int mt, input bit absf, input string name, output int acc);
        int n;
        exp_t t;
        n = 0;
        s_x = IW'(x);
        s_y = IW'(y);
        s_tvalid = 1'b1;
        while (s_tready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            check({name, "_accept_timeout"}, 0, 1, 0);
            s_tvalid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        t.ph = ph; t.ph_tol = pt; t.mag = mag; t.mag_tol = mt;
        t.abs_ph = absf; t.acc = acc; t.name = name;
        sb.push_back(t);
        s_tvalid = 1'b0;
        s_x = IW'($urandom);
        s_y = IW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 300) check("drain_timeout", sb.size(), 0, 0);
    endtask

    // x, y, expected phase, magnitude without / with gain compensation, abs-phase flag
    int    vx[10]     = '{16384, 0, 10000, -10000, -32768, 0, 3000, 20000, 0, -20000};
    int    vy[10]     = '{0, 16384, 10000, -10000, 0, 0, 4000, -15000, -16384, 15000};
    int    vph[10]    = '{0, 12868, 6434, -19302, 25736, 0, 7596, -5272, -12868, 20464};
    int    vraw[10]   = '{26981, 26981, 23288, 23288, 53961, 0, 8234, 41169, 26981, 41169};
    int    vcomp[10]  = '{16384, 16384, 14142, 14142, 32768, 0, 5000, 25000, 16384, 25000};
    bit    vabs[10]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    string vname[10]  = '{"x_axis", "y_axis", "diag_q1", "diag_q3", "neg_full", "zero",
                          "v3_4", "q4", "neg_y_axis", "q2"};

    initial begin
        int acc0, acc1, acc, mtol, ptol, n, rel, ph_chg, mag_chg, v_drop, r_high;
        logic signed [PW-1:0] ph0;
        logic [IW+1:0] mg0;

        rst = 1'b1; s_tvalid = 1'b0; s_x = '0; s_y = '0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", int'(s_tready), 0, 0);
        check("rst_m_tvalid", int'(m_tvalid), 0, 0);
        check("rst_m_phase", int'(m_phase), 0, 0);
        check("rst_m_mag", int'(m_mag), 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", int'(s_tready), 1, 0);

        acc0 = 0; acc1 = 0;
        for (int k = 0; k < 10; k++) begin
            mtol = (vraw[k] == 0) ? 0 : (GAIN_ON ? 3 : 8);
            ptol = (vraw[k] == 0) ? 0 : 4;
            send(vx[k], vy[k], vph[k], ptol, GAIN_ON ? vcomp[k] : vraw[k], mtol,
                 vabs[k], vname[k], acc);
            if (k == 0) acc0 = acc;
            if (k == 1) acc1 = acc;
        end
        check("throughput_gap", acc1 - acc0, LAT + 2, 0);
        drain();

        // Backpressure: result must hold while m_tready is low.
        m_tready = 1'b0;
        send(3000, 4000, 7596, 4, GAIN_ON ? 5000 : 8234, GAIN_ON ? 3 : 8, 1'b0, "bp", acc);
        n = 0;
        while (m_tvalid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_timeout", int'(n >= 100), 0, 0);
        ph0 = m_phase; mg0 = m_mag;
        ph_chg = 0; mag_chg = 0; v_drop = 0; r_high = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (m_phase !== ph0) ph_chg++;
            if (m_mag !== mg0) mag_chg++;
            if (m_tvalid !== 1'b1) v_drop++;
            if (s_tready !== 1'b0) r_high++;
        end
        check("bp_phase_changes", ph_chg, 0, 0);
        check("bp_mag_changes", mag_chg, 0, 0);
        check("bp_valid_drops", v_drop, 0, 0);
        check("bp_ready_high", r_high, 0, 0);
        m_tready = 1'b1;
        @(posedge clk); #1;
        check("ready_after_handshake", int'(s_tready), 1, 0);
        check("valid_after_handshake", int'(m_tvalid), 0, 0);

        // Reset during ROT iteration 5 abandons the sample.
        send(10000, 10000, 6434, 4, GAIN_ON ? 14142 : 23288, GAIN_ON ? 3 : 8, 1'b0, "aborted", acc);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        void'(sb.pop_back());
        check("midrst_m_tvalid", int'(m_tvalid), 0, 0);
        check("midrst_s_tready", int'(s_tready), 0, 0);
        rst = 1'b0;
        rel = cyc;
        send(20000, -15000, -5272, 4, GAIN_ON ? 25000 : 41169, GAIN_ON ? 3 : 8, 1'b0,
             "post_rst", acc);
        check("post_rst_accept_delay", acc - rel, 2, 0);
        drain();
        check("scoreboard_left", sb.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cordic_vector_atan2.md
# cordic_vector_atan2

Iterative CORDIC vectoring engine: the inverse of the sine/cosine wave generator. It accepts a signed Cartesian sample (x, y) and returns its phase atan2(y, x) and magnitude. The phase uses the same 1.2.13 radian fixed-point format that drives the wave generator, so measured phase can be fed straight back as phase input. It sits after I/Q mixing and filtering, for phase detection and demodulation.

## Interface
- IW, 16: width of signed s_x / s_y.
- PW, 16: phase width, fixed-point 1.2.(PW-3) radians; PW=16 gives pi = 0x6488 (25736).
- ITER, 14: micro-rotations per sample; legal range 1..PW-2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  engine idle, can accept a sample.
- s_x  in  IW  signed real/I component.
- s_y  in  IW  signed imaginary/Q component.
- m_tvalid  out  1  result valid.
- m_tready  in  1  downstream accepts the result.
- m_phase  out  PW  signed atan2(y, x), in [-pi, +pi].
- m_mag  out  IW+2  unsigned magnitude.

## Operation
- FSM states: IDLE, ROT, GAIN (only when the macro is defined), DONE.
- IDLE: s_tready=1. On s_tvalid&&s_tready, go to ROT with i=0 and load the pre-rotated registers. Internal x/y are IW+2 bits signed.
- Pre-rotation when x<0:
  - y>=0: (x,y)<=(y,-x), z<=+pi/2 (12868).
  - y<0: (x,y)<=(-y,x), z<=-pi/2.
  - Otherwise (x,y)<=(x,y), z<=0.
  - Sign-extend before negating, so -(-2^(IW-1)) does not overflow.
- ROT, one iteration per cycle, i=0..ITER-1, using arithmetic shifts:
  - y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i].
  - y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
  - Both updates use the old x and y.
- ATAN[i] = round(atan(2^-i)*2^(PW-3)). For PW=16 the table is 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1.
- After iteration ITER-1, go to GAIN, or to DONE if GAIN is compiled out.
- Output phase:
  - Saturate z to [-25736, +25736] (scaled for PW).
  - If the captured input was x=0 and y=0, m_phase=0 and m_mag=0. This is a zero flag set on accept.
- DONE:
  - m_tvalid=1. m_phase and m_mag are held stable until m_tready.
  - On m_tready, go to IDLE.
  - s_tready=0 in every state except IDLE.
- Inputs are sampled only on the accept edge and may change afterwards.

## Timing
- Reset values: s_tready=0, m_tvalid=0, m_phase=0, m_mag=0, state IDLE. s_tready rises the cycle after rst deasserts.
- Latency, accept edge to m_tvalid=1: ITER+1 cycles without the macro, ITER+2 with it.
- Throughput: one sample per ITER+3 cycles (macro off) when m_tready is held high.
- No accept is possible in the same cycle as a result handshake; IDLE always lasts at least one cycle.
- rst mid-operation abandons the sample and forces the reset values on the next edge. No result is emitted for it.
- m_tvalid stays high indefinitely under backpressure.

## Configuration
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - The GAIN state multiplies the final x by 19898 (0.60725*2^15) and takes the product >>15.
  - m_mag ≈ sqrt(x²+y²), error ≤ 2 LSB.
  - Adds one cycle of latency.
- Undefined:
  - No GAIN state. m_mag = raw final x ≈ 1.6468*sqrt(x²+y²).
  - No multiplier is inferred.

## Test plan
- (x,y)=(16384,0), macro off -> m_phase=0±2, m_mag=26981±4, m_tvalid exactly 15 cycles after the accept edge.
- (x,y)=(0,16384) -> m_phase=12868±4. (10000,10000) -> 6434±4. (-10000,-10000) -> -19302±4.
- (x,y)=(-32768,0) -> |m_phase| within 4 of 25736, never beyond ±25736. (0,0) -> m_phase=0, m_mag=0.
- With CORDIC_GAIN_COMP_EN, (3000,4000) -> m_mag=5000±2, latency 16 cycles.
- Hold m_tready=0 for 50 cycles after m_tvalid -> outputs stable, s_tready=0. Release -> handshake, s_tready=1 the next cycle.
- Assert rst during ROT iteration 5 -> next cycle m_tvalid=0, s_tready=0. Two cycles after release a new sample is accepted and produces the correct result.
